// File: rtl/spi_transaction_sequencer_if.sv
// Host-side stream and bit-level driver command signals for spi_transaction_sequencer.
// Optional abort/aborted signals exist only when SPI_SEQ_ABORT_EN is defined.
interface spi_transaction_sequencer_if #(
  parameter int WORD_BITS = 8,
  parameter int LEN_BITS  = 8
);
  logic                 start;
  logic [LEN_BITS-1:0]  length;
  logic                 ready;
  logic                 done;
  logic [WORD_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [WORD_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 drv_idle;
  logic                 drv_ack;
  logic                 drv_rdata;
  logic                 drv_do_enable;
  logic                 drv_do_disable;
  logic                 drv_do_transfer;
  logic                 drv_wdata;
`ifdef SPI_SEQ_ABORT_EN
  logic                 abort;
  logic                 aborted;

  modport slave (
    input  start, length, tx_data, tx_valid, drv_idle, drv_ack, drv_rdata, abort,
    output ready, done, tx_ready, rx_data, rx_valid,
           drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata, aborted
  );
  modport master (
    output start, length, tx_data, tx_valid, drv_idle, drv_ack, drv_rdata, abort,
    input  ready, done, tx_ready, rx_data, rx_valid,
           drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata, aborted
  );
`else
  modport slave (
    input  start, length, tx_data, tx_valid, drv_idle, drv_ack, drv_rdata,
    output ready, done, tx_ready, rx_data, rx_valid,
           drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata
  );
  modport master (
    output start, length, tx_data, tx_valid, drv_idle, drv_ack, drv_rdata,
    input  ready, done, tx_ready, rx_data, rx_valid,
           drv_do_enable, drv_do_disable, drv_do_transfer, drv_wdata
  );
`endif
endinterface

// File: rtl/spi_transaction_sequencer.sv
// Word-level SPI transaction controller: enable, length words of WORD_BITS driver transfers, disable.
// Define SPI_SEQ_ABORT_EN to add the abort input and aborted pulse output.
module spi_transaction_sequencer #(
  parameter int WORD_BITS = 8,
  parameter int LEN_BITS  = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  spi_transaction_sequencer_if.slave bus
);
  localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  typedef enum logic [3:0] {
    IDLE, EN_ISSUE, EN_WAIT, LOAD, BIT_ISSUE, BIT_WAIT, DIS_ISSUE, DIS_WAIT, DONE
  } state_t;

  state_t               state;
  logic [LEN_BITS-1:0]  word_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] shift_reg;
  logic [WORD_BITS-1:0] shift_next;
  logic                 out_bit;
`ifdef SPI_SEQ_ABORT_EN
  logic                 abort_pend;
`endif

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    out_bit    = 1'b0;
    shift_next = '0;
    if (MSB_FIRST != 0) begin
      out_bit    = shift_reg[WORD_BITS-1];
      shift_next = {shift_reg[WORD_BITS-2:0], bus.drv_rdata};
    end else begin
      out_bit    = shift_reg[0];
      shift_next = {bus.drv_rdata, shift_reg[WORD_BITS-1:1]};
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.tx_ready = (state == LOAD);

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      word_cnt            <= '0;
      bit_cnt             <= '0;
      shift_reg           <= '0;
      bus.rx_data         <= '0;
      bus.rx_valid        <= 1'b0;
      bus.done            <= 1'b0;
      bus.drv_do_enable   <= 1'b0;
      bus.drv_do_disable  <= 1'b0;
      bus.drv_do_transfer <= 1'b0;
      bus.drv_wdata       <= 1'b0;
`ifdef SPI_SEQ_ABORT_EN
      abort_pend          <= 1'b0;
      bus.aborted         <= 1'b0;
`endif
    end else begin
      bus.drv_do_enable   <= 1'b0;
      bus.drv_do_disable  <= 1'b0;
      bus.drv_do_transfer <= 1'b0;
      bus.done            <= 1'b0;
      bus.rx_valid        <= 1'b0;
`ifdef SPI_SEQ_ABORT_EN
      bus.aborted         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            word_cnt <= bus.length;
            state    <= EN_ISSUE;
          end
        end
        EN_ISSUE: begin
`ifdef SPI_SEQ_ABORT_EN
          if (bus.abort) abort_pend <= 1'b1;
`endif
          if (bus.drv_idle) begin
            bus.drv_do_enable <= 1'b1;
            state             <= EN_WAIT;
          end
        end
        EN_WAIT: begin
`ifdef SPI_SEQ_ABORT_EN
          if (bus.abort) abort_pend <= 1'b1;
          if (bus.drv_ack && (abort_pend || bus.abort)) state <= DIS_ISSUE;
          else
`endif
          if (bus.drv_ack) state <= (word_cnt != '0) ? LOAD : DIS_ISSUE;
        end
        LOAD: begin
`ifdef SPI_SEQ_ABORT_EN
          if (bus.abort) begin
            abort_pend <= 1'b1;
            state      <= DIS_ISSUE;
          end else
`endif
          if (bus.tx_valid) begin
            shift_reg <= bus.tx_data;
            bit_cnt   <= BIT_W'(WORD_BITS - 1);
            state     <= BIT_ISSUE;
          end
        end
        BIT_ISSUE: begin
`ifdef SPI_SEQ_ABORT_EN
          if (bus.abort) begin
            abort_pend <= 1'b1;
            state      <= DIS_ISSUE;
          end else
`endif
          if (bus.drv_idle) begin
            bus.drv_do_transfer <= 1'b1;
            bus.drv_wdata       <= out_bit;
            state               <= BIT_WAIT;
          end
        end
        BIT_WAIT: begin
`ifdef SPI_SEQ_ABORT_EN
          if (bus.abort) abort_pend <= 1'b1;
          // A pending abort drops the partial word once the in-flight bit completes.
          if (bus.drv_ack && (abort_pend || bus.abort)) state <= DIS_ISSUE;
          else
`endif
          if (bus.drv_ack) begin
            shift_reg <= shift_next;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              state   <= BIT_ISSUE;
            end else begin
              bus.rx_data  <= shift_next;
              bus.rx_valid <= 1'b1;
              word_cnt     <= word_cnt - 1'b1;
              state        <= (word_cnt != LEN_BITS'(1)) ? LOAD : DIS_ISSUE;
            end
          end
        end
        DIS_ISSUE: begin
          if (bus.drv_idle) begin
            bus.drv_do_disable <= 1'b1;
            state              <= DIS_WAIT;
          end
        end
        DIS_WAIT: begin
          if (bus.drv_ack) begin
            bus.done <= 1'b1;
`ifdef SPI_SEQ_ABORT_EN
            bus.aborted <= abort_pend;
            abort_pend  <= 1'b0;
`endif
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed bench for spi_transaction_sequencer: echoing driver model, MSB- and LSB-first instances.
module tb_spi_transaction_sequencer;
  localparam int WB = 8;
  localparam int LB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_transaction_sequencer_if #(.WORD_BITS(WB), .LEN_BITS(LB)) bus ();
  spi_transaction_sequencer_if #(.WORD_BITS(WB), .LEN_BITS(LB)) bus_l ();

  spi_transaction_sequencer #(.WORD_BITS(WB), .LEN_BITS(LB), .MSB_FIRST(1)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  spi_transaction_sequencer #(.WORD_BITS(WB), .LEN_BITS(LB), .MSB_FIRST(0)) dut_l (
    .clock(clock), .reset(reset), .bus(bus_l));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver model for the MSB-first instance: accepts a command when idle, acks 3 cycles later, echoes MOSI.
  logic busy, hold, cur_bit;
  int   lat;
  assign bus.drv_idle = !busy && !hold;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0; lat <= 0; cur_bit <= 1'b0;
      bus.drv_ack <= 1'b0; bus.drv_rdata <= 1'b0;
    end else begin
      bus.drv_ack <= 1'b0;
      if (busy) begin
        if (lat == 0) begin
          busy <= 1'b0; bus.drv_ack <= 1'b1; bus.drv_rdata <= cur_bit;
        end else lat <= lat - 1;
      end else if (!hold && (bus.drv_do_enable || bus.drv_do_disable || bus.drv_do_transfer)) begin
        busy <= 1'b1; lat <= 2; cur_bit <= bus.drv_wdata;
      end
    end
  end

  logic busy_l, hold_l, cur_bit_l;
  int   lat_l;
  assign bus_l.drv_idle = !busy_l && !hold_l;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_l <= 1'b0; lat_l <= 0; cur_bit_l <= 1'b0;
      bus_l.drv_ack <= 1'b0; bus_l.drv_rdata <= 1'b0;
    end else begin
      bus_l.drv_ack <= 1'b0;
      if (busy_l) begin
        if (lat_l == 0) begin
          busy_l <= 1'b0; bus_l.drv_ack <= 1'b1; bus_l.drv_rdata <= cur_bit_l;
        end else lat_l <= lat_l - 1;
      end else if (!hold_l && (bus_l.drv_do_enable || bus_l.drv_do_disable || bus_l.drv_do_transfer)) begin
        busy_l <= 1'b1; lat_l <= 2; cur_bit_l <= bus_l.drv_wdata;
      end
    end
  end

  // Monitors and TX feeder, all sampled on the falling edge.
  int en_cnt, dis_cnt, xfer_cnt, txr_cnt, done_cnt, proto_err, ab_cnt, both_cnt;
  logic [31:0] wseq;
  logic [WB-1:0] rx_q[$];
  logic [WB-1:0] tx_q[$];
  logic feed_en, take_pend;

  int xfer_l, done_l, proto_l, rxv_l;
  logic [31:0] wseq_l;
  logic [WB-1:0] rx_l;

  always @(negedge clock) begin
    if (bus.drv_do_enable) en_cnt++;
    if (bus.drv_do_disable) dis_cnt++;
    if (bus.drv_do_transfer) begin
      xfer_cnt++;
      wseq = {wseq[30:0], bus.drv_wdata};
    end
    if (bus.tx_ready) txr_cnt++;
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
    if (bus.done) done_cnt++;
    if ((32'(bus.drv_do_enable) + 32'(bus.drv_do_disable) + 32'(bus.drv_do_transfer)) > 1) proto_err++;
    if ((bus.drv_do_enable || bus.drv_do_disable || bus.drv_do_transfer) && !bus.drv_idle) proto_err++;
`ifdef SPI_SEQ_ABORT_EN
    if (bus.aborted) ab_cnt++;
    if (bus.aborted && bus.done) both_cnt++;
`endif
    if (take_pend && !reset) void'(tx_q.pop_front());
    bus.tx_valid = feed_en && (tx_q.size() > 0);
    bus.tx_data  = bus.tx_valid ? tx_q[0] : '0;
    take_pend    = bus.tx_valid && bus.tx_ready && !reset;

    if (bus_l.drv_do_transfer) begin
      xfer_l++;
      wseq_l = {wseq_l[30:0], bus_l.drv_wdata};
    end
    if (bus_l.rx_valid) begin
      rxv_l++;
      rx_l = bus_l.rx_data;
    end
    if (bus_l.done) done_l++;
    if ((bus_l.drv_do_enable || bus_l.drv_do_disable || bus_l.drv_do_transfer) && !bus_l.drv_idle) proto_l++;
  end

  task automatic clear_mon();
    en_cnt = 0; dis_cnt = 0; xfer_cnt = 0; txr_cnt = 0; done_cnt = 0;
    proto_err = 0; ab_cnt = 0; both_cnt = 0; wseq = '0;
    rx_q.delete();
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_start(input logic [LB-1:0] len);
    int n = 0;
    tick();
    while (!bus.ready && n < 200) begin tick(); n++; end
    bus.length = len;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 3000) begin tick(); n++; end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    tick();
  endtask

  task automatic wait_xfer(input string tag, input int target);
    int n = 0;
    while (xfer_cnt < target && n < 2000) begin tick(); n++; end
    check({tag, "_xfer_reached"}, xfer_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.length = '0;
    bus_l.start = 1'b0; bus_l.length = '0; bus_l.tx_valid = 1'b0; bus_l.tx_data = '0;
`ifdef SPI_SEQ_ABORT_EN
    bus.abort = 1'b0; bus_l.abort = 1'b0;
`endif
    hold = 1'b0; hold_l = 1'b0; feed_en = 1'b1; take_pend = 1'b0;
    xfer_l = 0; done_l = 0; proto_l = 0; rxv_l = 0; wseq_l = '0; rx_l = '0;
    clear_mon();

    // Reset state
    #12;
    check("rst_ready", bus.ready, 1);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_done_rxv", {bus.done, bus.rx_valid}, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_do", {bus.drv_do_enable, bus.drv_do_disable, bus.drv_do_transfer, bus.drv_wdata}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Two words, MSB first, echoing slave; an extra queued word keeps tx_valid high past the last LOAD
    clear_mon();
    tx_q = '{8'hA5, 8'h3C, 8'h77};
    do_start(8'd2);
    wait_done("t1");
    check("t1_enables", en_cnt, 1);
    check("t1_transfers", xfer_cnt, 16);
    check("t1_wdata_seq", wseq, 32'h0000A53C);
    check("t1_disables", dis_cnt, 1);
    check("t1_rx_count", rx_q.size(), 2);
    check("t1_rx0", rx_q.size() > 0 ? rx_q[0] : 8'h00, 8'hA5);
    check("t1_rx1", rx_q.size() > 1 ? rx_q[1] : 8'h00, 8'h3C);
    check("t1_done_count", done_cnt, 1);
    check("t1_extra_word_left", tx_q.size(), 1);
    check("t1_ready", bus.ready, 1);
    check("t1_protocol", proto_err, 0);
    tx_q.delete();
    tick();

    // Zero-length transaction
    clear_mon();
    do_start(8'd0);
    wait_done("t2");
    check("t2_enables", en_cnt, 1);
    check("t2_disables", dis_cnt, 1);
    check("t2_transfers", xfer_cnt, 0);
    check("t2_tx_ready_cycles", txr_cnt, 0);
    check("t2_rx_count", rx_q.size(), 0);
    check("t2_done_count", done_cnt, 1);
    check("t2_ready", bus.ready, 1);

    // LOAD stall with tx_valid withheld
    clear_mon();
    feed_en = 1'b0;
    tx_q = '{8'hFF};
    do_start(8'd1);
    begin
      int n = 0;
      while (!bus.tx_ready && n < 200) begin tick(); n++; end
    end
    check("t3_in_load", bus.tx_ready, 1);
    repeat (50) tick();
    check("t3_stall_tx_ready", bus.tx_ready, 1);
    check("t3_stall_cmds", en_cnt * 100 + dis_cnt * 10 + xfer_cnt, 100);
    feed_en = 1'b1;
    wait_done("t3");
    check("t3_transfers", xfer_cnt, 8);
    check("t3_rx", rx_q.size() > 0 ? rx_q[0] : 8'h00, 8'hFF);
    check("t3_disables", dis_cnt, 1);

    // LSB-first instance, driver held busy while in BIT_ISSUE
    begin
      int n = 0;
      bus_l.length = 8'd1;
      bus_l.start  = 1'b1;
      tick();
      bus_l.start  = 1'b0;
      while (!bus_l.tx_ready && n < 200) begin tick(); n++; end
      check("t4_in_load", bus_l.tx_ready, 1);
      bus_l.tx_valid = 1'b1;
      bus_l.tx_data  = 8'h01;
      hold_l = 1'b1;
      tick();
      bus_l.tx_valid = 1'b0;
      repeat (10) tick();
      check("t4_held_no_transfer", xfer_l, 0);
      hold_l = 1'b0;
      tick();
      tick();
      check("t4_single_pulse", xfer_l, 1);
      check("t4_first_bit", wseq_l[0], 1);
      n = 0;
      while (done_l == 0 && n < 2000) begin tick(); n++; end
      check("t4_done", done_l, 1);
      check("t4_transfers", xfer_l, 8);
      check("t4_wdata_seq", wseq_l, 32'h00000080);
      check("t4_rx", {24'h0, rx_l}, 32'h01);
      check("t4_rx_count", rxv_l, 1);
      check("t4_protocol", proto_l, 0);
    end

    // Asynchronous reset in the middle of a word
    clear_mon();
    tx_q = '{8'h5A};
    do_start(8'd1);
    wait_xfer("t5", 4);
    #2;
    reset = 1'b1;
    #1;
    check("t5_ready", bus.ready, 1);
    check("t5_tx_ready", bus.tx_ready, 0);
    check("t5_do", {bus.drv_do_enable, bus.drv_do_disable, bus.drv_do_transfer, bus.drv_wdata}, 0);
    check("t5_rx_data", bus.rx_data, 0);
    check("t5_pulses", {bus.done, bus.rx_valid}, 0);
    tx_q.delete();
    @(negedge clock);
    reset = 1'b0;
    clear_mon();
    tx_q = '{8'hC3};
    do_start(8'd1);
    wait_done("t5b");
    check("t5b_enables", en_cnt, 1);
    check("t5b_transfers", xfer_cnt, 8);
    check("t5b_rx", rx_q.size() > 0 ? rx_q[0] : 8'h00, 8'hC3);
    check("t5b_disables", dis_cnt, 1);
    check("t5b_protocol", proto_err, 0);

`ifdef SPI_SEQ_ABORT_EN
    // Abort while the third bit of word 1 of 3 is in flight
    clear_mon();
    tx_q = '{8'h11, 8'h22, 8'h33};
    do_start(8'd3);
    wait_xfer("t6", 3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_done("t6");
    check("t6_transfers", xfer_cnt, 3);
    check("t6_rx_count", rx_q.size(), 0);
    check("t6_disables", dis_cnt, 1);
    check("t6_aborted_count", ab_cnt, 1);
    check("t6_aborted_with_done", both_cnt, 1);
    check("t6_protocol", proto_err, 0);
    tx_q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/spi_transaction_sequencer.md
Name: spi_transaction_sequencer

Overview:
- Word-level transaction controller that sequences the bit-level SPI master driver through a complete chip-select transaction: enable, N words of WORD_BITS transfers, then disable.
- Accepts TX words over a valid/ready stream and returns each RX word as a one-cycle pulse.
- Sits between host logic (command/flash/ADC front-ends) and the single SPI driver instance. It is the only source of that driver's commands.

Parameters:
- WORD_BITS, 8: bits per word; each word is shifted as WORD_BITS driver transfers.
- LEN_BITS, 8: width of the length field; max transaction is 2^LEN_BITS-1 words.
- MSB_FIRST, 1: 1 = bit WORD_BITS-1 sent first and received first; 0 = LSB first.

Ports:
- clock  in  1  system clock, same domain as the driver.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin transaction; sampled only while ready=1.
- length  in  LEN_BITS  word count, latched on accepted start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when the transaction completes.
- tx_data  in  WORD_BITS  next word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  high in LOAD; a word transfers when tx_valid&tx_ready.
- rx_data  out  WORD_BITS  last received word; held until the next word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- drv_idle  in  1  driver idle.
- drv_ack  in  1  driver command-complete pulse.
- drv_rdata  in  1  driver received bit; valid on the drv_ack cycle.
- drv_do_enable  out  1  driver enable command.
- drv_do_disable  out  1  driver disable command.
- drv_do_transfer  out  1  driver transfer command.
- drv_wdata  out  1  bit to send; stable while drv_do_transfer=1.

Behaviour:
- Reset (async, any state): state=IDLE. All registered outputs are 0: done, rx_valid, rx_data, drv_do_*, drv_wdata, shift register, counters. ready=1 and tx_ready=0 follow combinationally. Reset mid-transaction abandons it with no disable issued; the driver is reset by the same system reset.
- States: IDLE, EN_ISSUE, EN_WAIT, LOAD, BIT_ISSUE, BIT_WAIT, DIS_ISSUE, DIS_WAIT, DONE.
- IDLE:
  - start=1 latches length into word_cnt, then goes to EN_ISSUE.
  - start is ignored in every other state.
- Command issue (EN/BIT/DIS_ISSUE):
  - When drv_idle=1, register the matching drv_do_* high for exactly one cycle and go to the matching *_WAIT.
  - If drv_idle=0, wait with all drv_do_* low.
  - At most one drv_do_* is high in any cycle.
- Command wait (*_WAIT):
  - Hold until drv_ack=1; drv_do_* stays low.
  - EN_WAIT+ack: go to LOAD if word_cnt!=0, else DIS_ISSUE.
- LOAD:
  - tx_ready=1. On tx_valid: shift_reg<=tx_data, bit_cnt<=WORD_BITS-1, go to BIT_ISSUE.
  - With no tx_valid, stall indefinitely; CS stays asserted.
- BIT_ISSUE: drv_wdata is driven from the shift register's output end (MSB if MSB_FIRST, else LSB) and is registered together with drv_do_transfer.
- BIT_WAIT+ack:
  - Shift drv_rdata into the opposite end of the shift register.
  - bit_cnt!=0: decrement and return to BIT_ISSUE.
  - bit_cnt==0: on the next edge rx_data<=completed word and rx_valid=1 for one cycle; word_cnt decrements.
  - Then go to LOAD if the new word_cnt!=0, else DIS_ISSUE.
- DIS_WAIT+ack: go to DONE.
- DONE: done=1 for one cycle, then IDLE; ready=1 on the following cycle.
- Boundary cases:
  - length=0: enable then disable, no tx_ready and no rx_valid, done pulses.
  - length=2^LEN_BITS-1: word_cnt does not wrap.
  - tx_valid held across LOAD exits: no extra word is taken.
- Per-bit sequencer overhead: ISSUE 1 cycle + WAIT, with the rest set by driver timing. The only timing assumption is the driver contract: do_* is honoured only while idle, and ack is a single-cycle pulse.

Optional Feature:
- SPI_SEQ_ABORT_EN defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in LOAD or BIT_ISSUE jumps to DIS_ISSUE.
  - In a *_WAIT state it is recorded and acted on after the pending drv_ack, so a driver command is never cut short. EN_WAIT+abort goes to DIS_ISSUE.
  - A partial word produces no rx_valid.
  - aborted pulses with done. abort in IDLE/DONE/DIS_* is ignored.
- Undefined: no port and no logic; the transaction always runs to length.

Test Plan:
- length=2, tx 0xA5 then 0x3C, MSB_FIRST=1, slave echoes its MOSI bit -> exactly 1 enable, 16 transfers with drv_wdata sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, then 1 disable; rx_valid twice with 0xA5 then 0x3C; one done pulse.
- length=0 -> drv_do_enable then drv_do_disable, tx_ready never 1, no rx_valid, done once; ready returns.
- length=1, tx_valid withheld 50 cycles after enable ack -> sequencer sits in LOAD with no drv_do_*; completes normally once 0xFF is presented.
- drv_idle held low 10 cycles in BIT_ISSUE -> drv_do_transfer stays 0, then pulses exactly once; MSB_FIRST=0 with tx 0x01 sends 1 first.
- reset asserted mid-word (bit 4 of 8) -> all outputs 0 immediately (asynchronous), ready=1; a new start with length=1 runs cleanly.
- SPI_SEQ_ABORT_EN: abort during BIT_WAIT of word 1 of 3 -> the pending ack is consumed, disable issued, no rx_valid for the partial word, done and aborted pulse together.
